// File: rtl/raid_wb_arbiter.sv
// raid_wb_arbiter: single owner of the three-disk write port.
// Arbitrates host stripe writes vs fixer write-backs, rotating parity.
`timescale 1ns/1ps
module raid_wb_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 12,
  parameter int ACK_TIMEOUT    = 16,
  parameter int MAX_FIX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_d0,
  input  logic [DATA_W-1:0] host_d1,
  output logic              host_ack,
  input  logic              fix_req,
  input  logic [ADDR_W-1:0] fix_addr,
  input  logic              fix_sel,
  input  logic [DATA_W-1:0] fix_data,
  output logic              fix_ack,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] wr_disk_0,
  output logic [DATA_W-1:0] wr_disk_1,
  output logic [DATA_W-1:0] wr_disk_2,
  output logic [2:0]        en_wr_mem,
  output logic [ADDR_W-1:0] address,
  output logic              out_valid,
  output logic              busy,
  output logic              fix_dropped,
  output logic              timeout_err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int SW = $clog2(MAX_FIX_STREAK + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_FIX_STREAK);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e            state_q;
  logic [TW-1:0]     tmo_q;
  logic [SW-1:0]     streak_q, streak_d;
  logic              host_ack_q, fix_ack_q, drop_q, err_q;
  logic              valid_q, busy_q;
  logic [2:0]        en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] disk0_q, disk1_q, disk2_q;
  logic [DATA_W-1:0] disk0_d, disk1_d, disk2_d;
  logic [DATA_W-1:0] d0, d1, par;
  logic              collide, host_win;
  logic              e0, e1, ep;
  logic [1:0]        par_pos;

  always_comb begin
    collide  = host_req && fix_req && (host_addr == fix_addr);
    host_win = collide ||
               (host_req && (!fix_req || streak_q == STREAK_MAX));
    addr_d   = host_win ? host_addr : fix_addr;
    par_pos  = 2'(addr_d % ADDR_W'(3));
    d0  = '0;
    d1  = '0;
    par = '0;
    if (host_win) begin
      d0  = host_d0;
      d1  = host_d1;
      par = host_d0 ^ host_d1;
    end else if (fix_sel) begin
      d1  = fix_data;
    end else begin
      d0  = fix_data;
    end
    // Enables follow the same slot rotation as the data words.
    e0 = host_win || !fix_sel;
    e1 = host_win || fix_sel;
    ep = host_win;
    disk0_d = d0;
    disk1_d = d1;
    disk2_d = par;
    en_d    = {ep, e1, e0};
    unique case (par_pos)
      2'd0: begin
        disk0_d = par;
        disk1_d = d0;
        disk2_d = d1;
        en_d    = {e1, e0, ep};
      end
      2'd1: begin
        disk0_d = d0;
        disk1_d = par;
        disk2_d = d1;
        en_d    = {e1, ep, e0};
      end
      default: begin
        disk0_d = d0;
        disk1_d = d1;
        disk2_d = par;
        en_d    = {ep, e1, e0};
      end
    endcase
    if (host_win || !host_req)
      streak_d = '0;
    else if (streak_q == STREAK_MAX)
      streak_d = STREAK_MAX;
    else
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      streak_q   <= '0;
      host_ack_q <= 1'b0;
      fix_ack_q  <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= '0;
      addr_q     <= '0;
      disk0_q    <= '0;
      disk1_q    <= '0;
      disk2_q    <= '0;
    end else begin
      host_ack_q <= 1'b0;
      fix_ack_q  <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= host_req || fix_req;
          if (host_req || fix_req) begin
            state_q    <= WRITE;
            tmo_q      <= '0;
            streak_q   <= streak_d;
            host_ack_q <= host_win;
            fix_ack_q  <= !host_win || collide;
            drop_q     <= collide;
            valid_q    <= 1'b1;
            en_q       <= en_d;
            addr_q     <= addr_d;
            disk0_q    <= disk0_d;
            disk1_q    <= disk1_d;
            disk2_q    <= disk2_d;
          end
        end
        default: begin
          if (mem_ack || tmo_q == TMO_LAST) begin
            state_q <= IDLE;
            err_q   <= !mem_ack;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            en_q    <= '0;
            addr_q  <= '0;
            disk0_q <= '0;
            disk1_q <= '0;
            disk2_q <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign host_ack    = host_ack_q;
  assign fix_ack     = fix_ack_q;
  assign fix_dropped = drop_q;
  assign timeout_err = err_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign en_wr_mem   = en_q;
  assign address     = addr_q;
  assign wr_disk_0   = disk0_q;
  assign wr_disk_1   = disk1_q;
  assign wr_disk_2   = disk2_q;

endmodule

// File: tb/tb_raid_wb_arbiter.sv
// tb_raid_wb_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_raid_wb_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 12;
  localparam int TMO  = 16;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_d0 = '0;
  logic [DW-1:0] host_d1 = '0;
  logic          host_ack;
  logic          fix_req = 1'b0;
  logic [AW-1:0] fix_addr = '0;
  logic          fix_sel = 1'b0;
  logic [DW-1:0] fix_data = '0;
  logic          fix_ack;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] wr_disk_0, wr_disk_1, wr_disk_2;
  logic [2:0]    en_wr_mem;
  logic [AW-1:0] address;
  logic          out_valid, busy, fix_dropped, timeout_err;

  int checks = 0;
  int passed = 0;
  int m_streak = 0;

  typedef struct packed {
    logic hack, fack, drop, err, ov, busy;
    logic [2:0]    en;
    logic [DW-1:0] w0, w1, w2;
    logic [AW-1:0] a;
  } snap_t;

  raid_wb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .ACK_TIMEOUT(TMO), .MAX_FIX_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .host_req(host_req), .host_addr(host_addr),
    .host_d0(host_d0), .host_d1(host_d1), .host_ack(host_ack),
    .fix_req(fix_req), .fix_addr(fix_addr), .fix_sel(fix_sel),
    .fix_data(fix_data), .fix_ack(fix_ack), .mem_ack(mem_ack),
    .wr_disk_0(wr_disk_0), .wr_disk_1(wr_disk_1),
    .wr_disk_2(wr_disk_2), .en_wr_mem(en_wr_mem),
    .address(address), .out_valid(out_valid), .busy(busy),
    .fix_dropped(fix_dropped), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic snap_t cap();
    snap_t s;
    s = {host_ack, fix_ack, fix_dropped, timeout_err, out_valid,
         busy, en_wr_mem, wr_disk_0, wr_disk_1, wr_disk_2, address};
    return s;
  endfunction

  // Expected first WRITE cycle for the requests currently driven.
  function automatic snap_t model_grant();
    snap_t e;
    logic col, hw;
    int p, sd0, sd1, s;
    logic [DW-1:0] w [3];
    e = '0;
    col = host_req && fix_req && (host_addr == fix_addr);
    hw = col || (host_req && (!fix_req || m_streak == MAXS));
    if (hw || !host_req) m_streak = 0;
    else if (m_streak < MAXS) m_streak++;
    e.a = hw ? host_addr : fix_addr;
    p = int'(e.a) % 3;
    sd0 = (p == 0) ? 1 : 0;
    sd1 = (p == 2) ? 1 : 2;
    for (int i = 0; i < 3; i++) w[i] = '0;
    if (hw) begin
      w[sd0] = host_d0;
      w[sd1] = host_d1;
      w[p]   = host_d0 ^ host_d1;
      e.en   = 3'b111;
    end else begin
      s = fix_sel ? sd1 : sd0;
      w[s] = fix_data;
      e.en = 3'(1 << s);
    end
    e.w0 = w[0];
    e.w1 = w[1];
    e.w2 = w[2];
    e.hack = hw;
    e.fack = !hw || col;
    e.drop = col;
    e.ov = 1'b1;
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic step(output snap_t s);
    @(posedge clk);
    @(negedge clk);
    s = cap();
  endtask

  // One write: mem_ack raised in WRITE cycle k (k >= TMO: never).
  task automatic test_write(input string name, input int k);
    snap_t e, h, s, x;
    e = model_grant();
    h = e;
    h.hack = 1'b0;
    h.fack = 1'b0;
    h.drop = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      step(s);
      x = (i == 0) ? e : h;
      checks++;
      if (s !== x)
        $display("FAIL %s wr%0d: got=%h exp=%h", name, i, s, x);
      else passed++;
      if (i == 0) begin
        if (e.hack) host_req = 1'b0;
        if (e.fack) fix_req = 1'b0;
      end
      mem_ack = (i == k);
      if (i == k) break;
    end
    step(s);
    mem_ack = 1'b0;
    x = '0;
    x.busy = 1'b1;
    x.err = (k >= TMO);
    checks++;
    if (s !== x)
      $display("FAIL %s idle: got=%h exp=%h", name, s, x);
    else passed++;
  endtask

  task automatic test_idle(input string name);
    snap_t s;
    mem_ack = 1'($urandom_range(0, 1));
    step(s);
    mem_ack = 1'b0;
    checks++;
    if (s !== '0)
      $display("FAIL %s: got=%h exp=0", name, s);
    else passed++;
  endtask

  task automatic test_reset();
    snap_t s;
    reset_n = 1'b0;
    #12;
    s = cap();
    checks++;
    if (s !== '0) $display("FAIL reset: got=%h exp=0", s);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    m_streak = 0;
    test_idle("idle_mem_ack");
  endtask

  task automatic test_host_write();
    host_req = 1'b1;
    host_addr = 8'd4;
    host_d0 = 12'hA5A;
    host_d1 = 12'h0F0;
    test_write("host_p1", 3);
  endtask

  task automatic test_fix_write();
    fix_req = 1'b1;
    fix_addr = 8'd3;
    fix_sel = 1'b0;
    fix_data = 12'h123;
    test_write("fix_p0", 1);
  endtask

  task automatic test_streak();
    host_req = 1'b1;
    host_addr = 8'd9;
    host_d0 = 12'h3C3;
    host_d1 = 12'h00F;
    fix_addr = 8'd5;
    fix_sel = 1'b1;
    fix_data = 12'h5A5;
    for (int g = 0; g < 6; g++) begin
      fix_req = 1'b1;
      test_write($sformatf("streak%0d", g), 0);
    end
    checks++;
    if (host_req !== 1'b0)
      $display("FAIL streak_host_served: got=%b exp=0", host_req);
    else passed++;
  endtask

  task automatic test_collision();
    host_req = 1'b1;
    fix_req = 1'b1;
    host_addr = 8'd7;
    fix_addr = 8'd7;
    host_d0 = 12'h111;
    host_d1 = 12'h222;
    fix_sel = 1'b0;
    fix_data = 12'hFFF;
    test_write("collide", 2);
  endtask

  task automatic test_timeout();
    host_req = 1'b1;
    host_addr = 8'd10;
    host_d0 = 12'h0AB;
    host_d1 = 12'hC00;
    test_write("tmo", 1000);
    test_idle("tmo_after");
    host_req = 1'b1;
    host_addr = 8'd11;
    test_write("tmo_last_ack", TMO - 1);
  endtask

  task automatic test_async_reset();
    snap_t s;
    host_req = 1'b1;
    host_addr = 8'd200;
    host_d0 = 12'h765;
    host_d1 = 12'h432;
    step(s);
    #3;
    reset_n = 1'b0;
    #1;
    s = cap();
    checks++;
    if (s !== '0) $display("FAIL async_reset: got=%h exp=0", s);
    else passed++;
    m_streak = 0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    test_write("after_reset", 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      if (!host_req && $urandom_range(0, 2) != 0) begin
        host_req = 1'b1;
        host_addr = AW'($urandom_range(0, 8));
        host_d0 = DW'($urandom);
        host_d1 = DW'($urandom);
      end
      if (!fix_req && $urandom_range(0, 2) != 0) begin
        fix_req = 1'b1;
        fix_addr = AW'($urandom_range(0, 8));
        fix_sel = 1'($urandom_range(0, 1));
        fix_data = DW'($urandom);
      end
      if (!host_req && !fix_req)
        test_idle($sformatf("rnd_idle%0d", n));
      else
        test_write($sformatf("rnd%0d", n),
                   ($urandom_range(0, 7) == 0) ? TMO :
                   int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_fix_write();
    test_streak();
    test_collision();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/raid_wb_arbiter.md
Name: raid_wb_arbiter

Overview:
- Single-owner controller for the three-disk write port (wr_disk_0..2, en_wr_mem, address, out_valid).
- Arbitrates between two requesters:
  - Host full-stripe writes: D0, D1 and parity P = D0 ^ D1.
  - Hamming-fixer correction write-backs: one data word; parity unchanged.
- Maps data onto disks by rotating parity (addr % 3), sequences the memory acknowledge, and enforces an acknowledge timeout.
- Sits between the host write path / fixer write-back logic and the disk memories.

Parameters:
ADDR_W, 8, address width
DATA_W, 12, Hamming codeword width
ACK_TIMEOUT, 16, max cycles in WRITE waiting for mem_ack (>=2)
MAX_FIX_STREAK, 4, consecutive fix grants allowed while host_req pending (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
host_req  in  1  host write request; payload stable until host_ack
host_addr  in  ADDR_W  host stripe address
host_d0  in  DATA_W  host data word 0 (encoded)
host_d1  in  DATA_W  host data word 1 (encoded)
host_ack  out  1  one-cycle accept pulse
fix_req  in  1  correction write-back request; payload stable until fix_ack
fix_addr  in  ADDR_W  correction address
fix_sel  in  1  0 = D0, 1 = D1
fix_data  in  DATA_W  corrected codeword
fix_ack  out  1  one-cycle accept (or drop) pulse
mem_ack  in  1  memory write-complete
wr_disk_0  out  DATA_W  disk 0 write data
wr_disk_1  out  DATA_W  disk 1 write data
wr_disk_2  out  DATA_W  disk 2 write data
en_wr_mem  out  3  per-disk write enable
address  out  ADDR_W  write address
out_valid  out  1  write command valid
busy  out  1  FSM not IDLE
fix_dropped  out  1  pulse: correction superseded by host write
timeout_err  out  1  pulse: mem_ack timeout

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM=IDLE, streak and timeout counters 0. Reset mid-WRITE aborts the write; no ack or err is emitted.
- All outputs are registered.
- FSM states:
  - IDLE: on the clock edge where any req=1, select a winner, latch its payload, go WRITE. Next cycle: ack=1 (one cycle), out_valid=1, busy=1. No req: stay IDLE, outputs 0.
  - WRITE: hold address, wr_disk_*, en_wr_mem, out_valid. mem_ack=1 sampled -> IDLE; next cycle all write outputs = 0. mem_ack during IDLE is ignored.
  - Timeout in WRITE: the counter increments each WRITE cycle with mem_ack=0. When the ACK_TIMEOUT-th WRITE cycle ends without ack -> IDLE; timeout_err=1 for the following cycle. If mem_ack=1 arrives in that final cycle, ack wins and there is no err.
- Throughput: one write per (2 + ack wait) cycles; IDLE always lasts at least one cycle between writes.
- Selection priority:
  - fix beats host by default.
  - Exception: host wins if host_req=1 and streak==MAX_FIX_STREAK.
  - streak increments on a fix grant while host_req=1. It clears on a host grant, or on a fix grant with host_req=0. It saturates at MAX_FIX_STREAK.
- Address collision: host_req and fix_req both 1 with fix_addr==host_addr.
  - Host is granted; the streak rule does not apply.
  - fix_ack and fix_dropped pulse in the same cycle as host_ack.
  - The correction is discarded, because the full-stripe write supersedes it.
- Disk mapping, with p = addr % 3 (computed on the latched address):
  - p=0: D0->disk1, D1->disk2, P->disk0
  - p=1: D0->disk0, D1->disk2, P->disk1
  - p=2: D0->disk0, D1->disk1, P->disk2
- Host grant: en_wr_mem=3'b111; all three wr_disk loaded per the mapping; P = d0 ^ d1 (the linear code keeps P a valid codeword).
- Fix grant: exactly one en_wr_mem bit set, at the disk that the mapping assigns to fix_sel. That wr_disk = fix_data; the other wr_disk outputs = 0.
- busy=1 in WRITE and in the first IDLE cycle after it.

Test Plan:
1. Host req, addr=8'd4 (p=1), d0=12'hA5A, d1=12'h0F0, mem_ack 3 cycles after out_valid -> next cycle host_ack=1, en_wr_mem=3'b111, wr_disk_0=A5A, wr_disk_1=AAA, wr_disk_2=0F0, address=4; outputs cleared the cycle after ack.
2. Fix req, addr=8'd3 (p=0), fix_sel=0, data=12'h123 -> fix_ack=1, en_wr_mem=3'b010, wr_disk_1=123, wr_disk_0=wr_disk_2=0.
3. Fix addr=5, sel=1 (p=2) plus host addr=9, both held, MAX_FIX_STREAK=4, fix re-requesting each time -> four fix grants (en_wr_mem=3'b010), then host grant (3'b111), then fix again.
4. Host and fix both at addr=8'd7 in the same cycle -> host_ack, fix_ack, fix_dropped all 1 in the same cycle; en_wr_mem=3'b111; the fix data is never written.
5. Host write with no mem_ack, ACK_TIMEOUT=16 -> out_valid high exactly 16 cycles, then timeout_err pulse, busy=0, next request accepted. Repeat with mem_ack on the 16th cycle -> no timeout_err.
6. reset_n pulled low in the middle of WRITE (async, not clock-aligned) -> all outputs 0 immediately; after release, a pending host_req is regranted normally.
